// File: rtl/sr_latch_writer.sv
// sr_latch_writer
// Drive-side write controller for an external SR latch. A valid/ready request
// becomes a mutually exclusive S or R pulse of PULSE_CYC cycles, followed by
// RECOVER_CYC cycles with both drives low. The latch is then read back through a
// two-flop synchroniser, and the controller reports done/err and updates its
// write and error counters.
module sr_latch_writer #(
  parameter int PULSE_CYC   = 2,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic             wr_data,
  output logic             wr_ready,
  output logic             s_out,
  output logic             r_out,
  input  logic             q_in,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_RECOVER = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // The phase counter has to reach the longer of the two timed phases.
  localparam int PH_MAX = (PULSE_CYC > RECOVER_CYC) ? PULSE_CYC : RECOVER_CYC;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]  PH_PULSE_LAST   = PH_W'(PULSE_CYC - 1);
  localparam logic [PH_W-1:0]  PH_RECOVER_LAST = PH_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALL_ONES    = {CNT_W{1'b1}};

  state_t          state_r;
  state_t          state_s;
  logic [PH_W-1:0] ph_cnt_r;
  logic [PH_W-1:0] ph_cnt_s;
  logic            data_r;
  logic            data_s;
  logic            q_meta_r;
  logic            q_sync_r;
  logic            mismatch_s;

  // Saturating increment used by the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == CNT_ALL_ONES) begin
      sat_inc = val;
    end else begin
      sat_inc = val + CNT_ONE;
    end
  endfunction

  // Only the second flop of the synchroniser is ever compared.
  assign mismatch_s = (q_sync_r != data_r);

  // Two-flop synchroniser for the asynchronous latch readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_meta_r <= 1'b0;
      q_sync_r <= 1'b0;
    end else begin
      q_meta_r <= q_in;
      q_sync_r <= q_meta_r;
    end
  end

  // FSM state, phase counter and captured write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ph_cnt_r <= {PH_W{1'b0}};
      data_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ph_cnt_r <= ph_cnt_s;
      data_r   <= data_s;
    end
  end

  // Next-state logic. The write value is captured only when a request is accepted.
  always_comb begin
    state_s  = state_r;
    ph_cnt_s = ph_cnt_r;
    data_s   = data_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_valid) begin
          state_s  = ST_PULSE;
          ph_cnt_s = {PH_W{1'b0}};
          data_s   = wr_data;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (ph_cnt_r == PH_PULSE_LAST) begin
          state_s  = ST_RECOVER;
          ph_cnt_s = {PH_W{1'b0}};
        end else begin
          ph_cnt_s = ph_cnt_r + PH_W'(1);
        end
      end
      ST_RECOVER: begin
        if (ph_cnt_r == PH_RECOVER_LAST) begin
          state_s  = ST_DONE;
          ph_cnt_s = {PH_W{1'b0}};
        end else begin
          ph_cnt_s = ph_cnt_r + PH_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s  = ST_IDLE;
        ph_cnt_s = {PH_W{1'b0}};
      end
    endcase
  end

  // Registered outputs, decoded from the next state so that they change on the
  // same edge as the state. S and R are both qualified by the single PULSE
  // decode and by opposite polarities of one bit, so they can never be high
  // together. Reset forces both low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      wr_ready <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_cnt   <= {CNT_W{1'b0}};
      err_cnt  <= {CNT_W{1'b0}};
    end else begin
      s_out    <= (state_s == ST_PULSE) &  data_s;
      r_out    <= (state_s == ST_PULSE) & ~data_s;
      wr_ready <= (state_s == ST_IDLE);
      done     <= (state_s == ST_DONE);
      err      <= (state_s == ST_DONE) & mismatch_s;
      if (state_s == ST_DONE) begin
        wr_cnt <= wr_cnt + CNT_ONE;
        if (mismatch_s) begin
          err_cnt <= sat_inc(err_cnt);
        end else begin
          err_cnt <= err_cnt;
        end
      end else begin
        wr_cnt  <= wr_cnt;
        err_cnt <= err_cnt;
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_writer.sv
// tb_sr_latch_writer
// Self-checking bench for sr_latch_writer. The external SR latch is modelled
// here, with an optional stuck-at-0 fault. Expected waveforms and counters come
// from the write protocol's timing rules: a pulse of P cycles, done at P+R
// cycles, ready low for P+R+1 cycles, a wrapping write count and a saturating
// error count.
module tb_sr_latch_writer;

  localparam int P   = 2;
  localparam int R   = 2;
  localparam int W   = 8;
  localparam int LAT = P + R;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_data  = 1'b0;
  logic         wr_ready;
  logic         s_out;
  logic         r_out;
  logic         q_in;
  logic         done;
  logic         err;
  logic [W-1:0] wr_cnt;
  logic [W-1:0] err_cnt;

  logic latch_q = 1'b0;
  logic stuck   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int exp_wr   = 0;
  int exp_err  = 0;

  sr_latch_writer #(.PULSE_CYC(P), .RECOVER_CYC(R), .CNT_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .done     (done),
    .err      (err),
    .wr_cnt   (wr_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  assign q_in = latch_q;

  // SR latch model with an optional stuck-at-0 fault.
  always @(posedge clk) begin
    if (stuck) latch_q <= 1'b0;
    else if (s_out && !r_out) latch_q <= 1'b1;
    else if (r_out && !s_out) latch_q <= 1'b0;
  end

  // S and R must never be high together, in any cycle.
  always @(negedge clk) begin
    checks++;
    if (s_out === 1'b1 && r_out === 1'b1) begin
      failures++;
      $display("FAIL sr_overlap t=%0t s_out=%b r_out=%b required not both 1", $time, s_out, r_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete write: wait for ready, present the request for one accept edge,
  // then check every cycle up to the return to IDLE against the timing rules.
  task automatic do_write(input logic d, input logic nd, input logic hold);
    int   w;
    logic exp_q;
    logic exp_e;
    w = 0;
    while (wr_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (w >= 20) begin
      failures++;
      $display("FAIL ready_wait got wr_ready=%b required 1 within 20 cycles", wr_ready);
    end
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_data  = nd;
    wr_valid = hold;
    exp_q = stuck ? 1'b0 : d;
    exp_e = (exp_q != d);
    for (int k = 0; k <= LAT + 1; k++) begin
      if (k > 0) step();
      checks++;
      if (s_out !== ((k < P) && d)) begin
        failures++;
        $display("FAIL s_out k=%0d d=%b got=%b required=%b", k, d, s_out, ((k < P) && d));
      end
      checks++;
      if (r_out !== ((k < P) && !d)) begin
        failures++;
        $display("FAIL r_out k=%0d d=%b got=%b required=%b", k, d, r_out, ((k < P) && !d));
      end
      checks++;
      if (done !== (k == LAT)) begin
        failures++;
        $display("FAIL done k=%0d got=%b required=%b", k, done, (k == LAT));
      end
      checks++;
      if (wr_ready !== (k == LAT + 1)) begin
        failures++;
        $display("FAIL wr_ready k=%0d got=%b required=%b", k, wr_ready, (k == LAT + 1));
      end
      if (k == LAT) begin
        exp_wr = (exp_wr + 1) % (1 << W);
        if (exp_e && exp_err < (1 << W) - 1) exp_err++;
        checks++;
        if (err !== exp_e) begin
          failures++;
          $display("FAIL err d=%b stuck=%b got=%b required=%b", d, stuck, err, exp_e);
        end
        checks++;
        if (wr_cnt !== W'(exp_wr)) begin
          failures++;
          $display("FAIL wr_cnt got=%0d required=%0d", wr_cnt, exp_wr);
        end
        checks++;
        if (err_cnt !== W'(exp_err)) begin
          failures++;
          $display("FAIL err_cnt got=%0d required=%0d", err_cnt, exp_err);
        end
      end else begin
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL err_idle k=%0d got=%b required=0", k, err);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({s_out, r_out, done, err} !== 4'b0000 || wr_cnt !== 8'd0 || err_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset_state got s=%b r=%b done=%b err=%b wr_cnt=%0d err_cnt=%0d required all 0",
                 s_out, r_out, done, err, wr_cnt, err_cnt);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b required=1", wr_ready);
    end
    exp_wr  = 0;
    exp_err = 0;
  endtask

  task automatic test_set_then_clear();
    do_write(1'b1, 1'b0, 1'b0);
    do_write(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic d;
    d = 1'($urandom_range(1, 0));
    for (int i = 0; i < 6; i++) begin
      do_write(d, ~d, (i < 5));
      d = ~d;
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_random();
    logic d;
    int   gap;
    for (int i = 0; i < 30; i++) begin
      d     = 1'($urandom_range(1, 0));
      stuck = ($urandom_range(3, 0) == 0);
      gap   = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) step();
      do_write(d, 1'($urandom_range(1, 0)), 1'b0);
    end
    stuck = 1'b0;
  endtask

  task automatic test_err_saturation();
    stuck = 1'b1;
    for (int i = 0; i < 260; i++) begin
      do_write(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL err_cnt_saturate got=%0h required=ff", err_cnt);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    wr_valid = 1'b1;
    wr_data  = 1'b1;
    step();
    wr_valid = 1'b0;
    checks++;
    if (s_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pulse got s_out=%b required=1", s_out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_wr  = 0;
    exp_err = 0;
    checks++;
    if (s_out !== 1'b0 || r_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_drive got s=%b r=%b done=%b required 0 0 0", s_out, r_out, done);
    end
    checks++;
    if (wr_cnt !== 8'd0 || err_cnt !== 8'd0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_state got wr_cnt=%0d err_cnt=%0d wr_ready=%b required 0 0 1",
               wr_cnt, err_cnt, wr_ready);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || s_out !== 1'b0 || r_out !== 1'b0) begin
        failures++;
        $display("FAIL midrst_quiet i=%0d got done=%b s=%b r=%b required 0 0 0", i, done, s_out, r_out);
      end
    end
  endtask

  task automatic test_write_same();
    do_write(1'b1, 1'b1, 1'b0);
    do_write(1'b1, 1'b1, 1'b0);
    checks++;
    if (wr_cnt !== 8'd2) begin
      failures++;
      $display("FAIL same_value_cnt got=%0d required=2", wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_set_then_clear();
    test_back_to_back();
    test_random();
    test_err_saturation();
    test_reset_mid_write();
    test_write_same();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
